// File: rtl/pa_ctrl_seq.sv
// pa_ctrl_seq -- bus initiator for the PA control peripheral (PD / MODE regs).
//
// It turns one-shot start/stop commands from the radio FSM into register-write
// sequences on the valid/address/wdata/wstrb/ready bus. On power-up it clears
// PD, waits a programmable settle time and then writes MODE. On power-down it
// clears MODE and then sets PD.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, stop    one-cycle command pulses (stop wins when both are high)
//   mode_sel       PA mode written by a power-up or mode-change sequence
//   settle_cycles  delay between the PD=0 write and the MODE write
//   busy, done     sequence in progress / 1-cycle end-of-sequence pulse
//   err            sticky bus timeout, cleared by the next accepted command
//   pa_on          PA powered and mode programmed
//   m_*            bus master side (m_ready is the peripheral acknowledge)
module pa_ctrl_seq #(
   parameter int   DATA_W    = 32,
   parameter logic PD_ADDR   = 1'b0,
   parameter logic MODE_ADDR = 1'b1,
   parameter int   TIMEOUT   = 15,
   parameter int   CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode_sel,
   input  logic [CNT_W-1:0]  settle_cycles,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              pa_on,
   output logic              m_valid,
   output logic              m_address,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wstrb,
   input  logic              m_ready
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_OFF, S_UP_PD, S_SETTLE, S_UP_MODE, S_ON, S_DN_MODE, S_DN_PD
   } state_t;

   state_t            state;
   logic              gap;        // 0: REQ phase, 1: one idle cycle after ready
   logic [CNT_W-1:0]  scnt;
   logic [TW-1:0]     tcnt;
   logic [1:0]        mode_lat;
   logic              pend_stop;

   // The strobe is only meaningful with valid; both come from the same flop.
   assign m_wstrb = m_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_OFF;
         gap       <= 1'b0;
         scnt      <= '0;
         tcnt      <= '0;
         mode_lat  <= 2'd0;
         pend_stop <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         pa_on     <= 1'b0;
         m_valid   <= 1'b0;
         m_address <= 1'b0;
         m_wdata   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_OFF: begin
               if (stop || pend_stop) begin
                  // Already off: no bus traffic, just acknowledge.
                  pend_stop <= 1'b0;
                  err       <= 1'b0;
                  done      <= 1'b1;
               end else if (start) begin
                  mode_lat  <= mode_sel;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_UP_PD;
                  gap       <= 1'b0;
                  tcnt      <= '0;
                  m_valid   <= 1'b1;
                  m_address <= PD_ADDR;
                  m_wdata   <= '0;
               end
            end
            S_ON: begin
               if (stop || pend_stop) begin
                  pend_stop <= 1'b0;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_DN_MODE;
                  gap       <= 1'b0;
                  tcnt      <= '0;
                  m_valid   <= 1'b1;
                  m_address <= MODE_ADDR;
                  m_wdata   <= '0;
               end else if (start) begin
                  // Mode change: PA already powered, rewrite MODE only.
                  mode_lat  <= mode_sel;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_UP_MODE;
                  gap       <= 1'b0;
                  tcnt      <= '0;
                  m_valid   <= 1'b1;
                  m_address <= MODE_ADDR;
                  m_wdata   <= DATA_W'(mode_sel);
               end
            end
            S_SETTLE: begin
               pend_stop <= pend_stop | stop;
               if (scnt == '0) begin
                  state     <= S_UP_MODE;
                  gap       <= 1'b0;
                  tcnt      <= '0;
                  m_valid   <= 1'b1;
                  m_address <= MODE_ADDR;
                  m_wdata   <= DATA_W'(mode_lat);
               end else begin
                  scnt <= scnt - 1'b1;
               end
            end
            default: begin
               // Write states: REQ until ready, then one GAP cycle because the
               // peripheral's registered ready lingers one cycle after valid.
               pend_stop <= pend_stop | stop;
               if (!gap) begin
                  if (m_ready) begin
                     m_valid <= 1'b0;
                     gap     <= 1'b1;
                  end else if (tcnt == TW'(TIMEOUT - 1)) begin
                     // Abort: peripheral state is unknown, fall back to OFF.
                     m_valid   <= 1'b0;
                     err       <= 1'b1;
                     pa_on     <= 1'b0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     pend_stop <= 1'b0;
                     state     <= S_OFF;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end else begin
                  gap <= 1'b0;
                  case (state)
                     S_UP_PD: begin
                        state <= S_SETTLE;
                        scnt  <= settle_cycles;
                     end
                     S_UP_MODE: begin
                        state <= S_ON;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pa_on <= 1'b1;
                     end
                     S_DN_MODE: begin
                        state     <= S_DN_PD;
                        tcnt      <= '0;
                        m_valid   <= 1'b1;
                        m_address <= PD_ADDR;
                        m_wdata   <= DATA_W'(1);
                     end
                     default: begin
                        state <= S_OFF;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pa_on <= 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pa_ctrl_seq.sv
// Directed bench for pa_ctrl_seq: a cycle-accurate vector table for a short
// power-up/power-down, then hand sequences for settle, timeout, command
// collisions, mode change and mid-sequence reset. The peripheral is modelled
// with a registered ready (ready follows valid one cycle late).
module tb_pa_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0;
   logic [1:0]  mode_sel = 2'd0;
   logic [15:0] settle_cycles = 16'd0;
   logic        busy, done, err, pa_on;
   logic        m_valid, m_address, m_wstrb, m_ready;
   logic [31:0] m_wdata;
   logic        hold = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   pa_ctrl_seq dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_sel(mode_sel),
      .settle_cycles(settle_cycles), .busy(busy), .done(done), .err(err),
      .pa_on(pa_on), .m_valid(m_valid), .m_address(m_address),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   // Peripheral: registered ready, forced low while hold is set.
   always @(posedge clk or posedge rst)
      if (rst) m_ready <= 1'b0;
      else     m_ready <= hold ? 1'b0 : m_valid;

   // Bus monitor.
   logic [32:0] wr_q[$];
   int          gap_q[$];
   int          hi_q[$];
   int          n_done = 0, n_busy = 0, vlow = 0, vhigh = 0;
   logic        prev_v = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         if (m_valid && m_ready) wr_q.push_back({m_address, m_wdata});
         if (done) n_done++;
         if (busy) n_busy++;
         if (m_valid && !prev_v) gap_q.push_back(vlow);
         if (!m_valid && prev_v) hi_q.push_back(vhigh);
         if (m_valid) begin vlow = 0; vhigh++; end
         else begin vlow++; vhigh = 0; end
         prev_v = m_valid;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic cmd(input logic st, input logic sp, input logic [1:0] m, input logic [15:0] sc);
      start = st; stop = sp; mode_sel = m; settle_cycles = sc;
      cyc();
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_done(input int max, input string nm);
      for (int i = 0; i < max && done !== 1'b1; i++) cyc();
      chk({nm, " done seen"}, 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; hold = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
   endtask

   typedef struct {
      logic        st, sp;
      logic [1:0]  m;
      logic        busy, done, pa_on, err, valid, addr;
      logic [31:0] wdata;
   } vec_t;

   function automatic vec_t v(input logic st, sp, input logic [1:0] m,
                              input logic b, d, p, e, val, a, input logic [31:0] w);
      vec_t r;
      r.st = st; r.sp = sp; r.m = m; r.busy = b; r.done = d; r.pa_on = p;
      r.err = e; r.valid = val; r.addr = a; r.wdata = w;
      return r;
   endfunction

   vec_t vt[17];
   int   base_w, base_d, base_b;

   initial begin
      //               st sp m   bs dn pa er vl ad wdata
      vt[0]  = v(1, 0, 2, 1, 0, 0, 0, 1, 0, 0);  // OFF+start
      vt[1]  = v(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      vt[2]  = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // ready seen -> GAP
      vt[3]  = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // SETTLE (0 cycles)
      vt[4]  = v(0, 0, 0, 1, 0, 0, 0, 1, 1, 2);  // MODE write
      vt[5]  = v(1, 0, 3, 1, 0, 0, 0, 1, 1, 2);  // start while busy: ignored
      vt[6]  = v(0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
      vt[7]  = v(0, 0, 0, 0, 1, 1, 0, 0, 1, 2);  // done + pa_on
      vt[8]  = v(0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
      vt[9]  = v(0, 1, 0, 1, 0, 1, 0, 1, 1, 0);  // ON+stop
      vt[10] = v(0, 0, 0, 1, 0, 1, 0, 1, 1, 0);
      vt[11] = v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
      vt[12] = v(0, 0, 0, 1, 0, 1, 0, 1, 0, 1);  // PD=1 after one gap cycle
      vt[13] = v(0, 0, 0, 1, 0, 1, 0, 1, 0, 1);
      vt[14] = v(0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
      vt[15] = v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      vt[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset state.
      cyc(); cyc();
      chk("rst busy",  64'(busy), 0);
      chk("rst done",  64'(done), 0);
      chk("rst err",   64'(err), 0);
      chk("rst pa_on", 64'(pa_on), 0);
      chk("rst valid", 64'(m_valid), 0);
      chk("rst wstrb", 64'(m_wstrb), 0);
      chk("rst addr",  64'(m_address), 0);
      chk("rst wdata", 64'(m_wdata), 0);
      rst = 1'b0;
      cyc();

      // Cycle-accurate table, settle_cycles = 0.
      for (int i = 0; i < 17; i++) begin
         start = vt[i].st; stop = vt[i].sp; mode_sel = vt[i].m; settle_cycles = 16'd0;
         cyc();
         chk($sformatf("vec%0d busy", i),  64'(busy),      64'(vt[i].busy));
         chk($sformatf("vec%0d done", i),  64'(done),      64'(vt[i].done));
         chk($sformatf("vec%0d pa_on", i), 64'(pa_on),     64'(vt[i].pa_on));
         chk($sformatf("vec%0d err", i),   64'(err),       64'(vt[i].err));
         chk($sformatf("vec%0d valid", i), 64'(m_valid),   64'(vt[i].valid));
         chk($sformatf("vec%0d wstrb", i), 64'(m_wstrb),   64'(vt[i].valid));
         chk($sformatf("vec%0d addr", i),  64'(m_address), 64'(vt[i].addr));
         chk($sformatf("vec%0d wdata", i), 64'(m_wdata),   64'(vt[i].wdata));
      end
      start = 1'b0; stop = 1'b0;
      cyc();

      // Power-up with settle 5, mode 2.
      base_w = wr_q.size(); base_d = n_done; base_b = n_busy;
      cmd(1, 0, 2, 16'd5);
      wait_done(60, "up5");
      cyc(); cyc();
      chk("up5 nwr", 64'(wr_q.size() - base_w), 2);
      if (wr_q.size() >= base_w + 2) begin
         chk("up5 wr0", 64'(wr_q[base_w]),   {31'd0, 1'b0, 32'd0});
         chk("up5 wr1", 64'(wr_q[base_w+1]), {31'd0, 1'b1, 32'd2});
      end
      chk("up5 idle>=5", 64'(gap_q[$] >= 5), 1);
      chk("up5 busy cycles", 64'(n_busy - base_b), 12);
      chk("up5 ndone", 64'(n_done - base_d), 1);
      chk("up5 pa_on", 64'(pa_on), 1);

      // Power-down.
      base_w = wr_q.size(); base_b = n_busy;
      cmd(0, 1, 0, 16'd0);
      wait_done(60, "dn");
      cyc();
      chk("dn nwr", 64'(wr_q.size() - base_w), 2);
      if (wr_q.size() >= base_w + 2) begin
         chk("dn wr0", 64'(wr_q[base_w]),   {31'd0, 1'b1, 32'd0});
         chk("dn wr1", 64'(wr_q[base_w+1]), {31'd0, 1'b0, 32'd1});
      end
      chk("dn gap", 64'(gap_q[$]), 1);
      chk("dn busy cycles", 64'(n_busy - base_b), 6);
      chk("dn pa_on", 64'(pa_on), 0);

      // Timeout during UP_PD.
      hold = 1'b1;
      cmd(1, 0, 1, 16'd0);
      wait_done(40, "to");
      chk("to err", 64'(err), 1);
      chk("to pa_on", 64'(pa_on), 0);
      chk("to valid", 64'(m_valid), 0);
      chk("to busy", 64'(busy), 0);
      cyc();
      chk("to valid run", 64'(hi_q[$]), 15);
      hold = 1'b0;
      cmd(1, 0, 1, 16'd0);
      chk("to err cleared", 64'(err), 0);
      chk("to busy again", 64'(busy), 1);
      wait_done(60, "to recover");
      chk("to recover pa_on", 64'(pa_on), 1);

      // start+stop together from OFF: stop wins, no traffic.
      do_reset();
      base_w = wr_q.size(); base_d = n_done;
      cmd(1, 1, 3, 16'd0);
      chk("ss done", 64'(done), 1);
      chk("ss valid", 64'(m_valid), 0);
      chk("ss busy", 64'(busy), 0);
      cyc(); cyc(); cyc();
      chk("ss nwr", 64'(wr_q.size() - base_w), 0);
      chk("ss ndone", 64'(n_done - base_d), 1);

      // stop during UP_PD: full up, then down, two done pulses.
      base_w = wr_q.size(); base_d = n_done;
      cmd(1, 0, 1, 16'd0);
      cmd(0, 1, 0, 16'd0);
      for (int i = 0; i < 60; i++) cyc();
      chk("pend ndone", 64'(n_done - base_d), 2);
      chk("pend nwr", 64'(wr_q.size() - base_w), 4);
      if (wr_q.size() >= base_w + 4) begin
         chk("pend wr0", 64'(wr_q[base_w]),   {31'd0, 1'b0, 32'd0});
         chk("pend wr1", 64'(wr_q[base_w+1]), {31'd0, 1'b1, 32'd1});
         chk("pend wr2", 64'(wr_q[base_w+2]), {31'd0, 1'b1, 32'd0});
         chk("pend wr3", 64'(wr_q[base_w+3]), {31'd0, 1'b0, 32'd1});
      end
      chk("pend pa_on", 64'(pa_on), 0);

      // Mode change from ON.
      cmd(1, 0, 1, 16'd0);
      wait_done(60, "mc up");
      cyc();
      base_w = wr_q.size();
      cmd(1, 0, 3, 16'd0);
      wait_done(60, "mc");
      cyc();
      chk("mc nwr", 64'(wr_q.size() - base_w), 1);
      if (wr_q.size() >= base_w + 1)
         chk("mc wr0", 64'(wr_q[base_w]), {31'd0, 1'b1, 32'd3});
      chk("mc pa_on", 64'(pa_on), 1);

      // Reset during SETTLE.
      do_reset();
      cmd(1, 0, 2, 16'd100);
      for (int i = 0; i < 5; i++) cyc();
      chk("rs busy pre", 64'(busy), 1);
      rst = 1'b1;
      #1;
      chk("rs valid", 64'(m_valid), 0);
      chk("rs busy", 64'(busy), 0);
      chk("rs pa_on", 64'(pa_on), 0);
      cyc();
      rst = 1'b0;
      cyc();
      base_w = wr_q.size();
      cmd(1, 0, 2, 16'd0);
      wait_done(60, "rs resume");
      cyc();
      chk("rs nwr", 64'(wr_q.size() - base_w), 2);
      chk("rs pa_on", 64'(pa_on), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pa_ctrl_seq.md
Name: pa_ctrl_seq

Overview:
- Bus initiator that drives the PA control peripheral (pd / mode registers) over the native valid/address/wdata/wstrb/ready interface.
- Turns one-shot power-up / power-down commands from the radio controller into timed register-write sequences.
- On power-up, inserts a programmable PA settle delay between clearing PD and writing MODE.
- Sits between the radio FSM and the PA peripheral; it is the sole master of that peripheral's bus.

Parameters:
- DATA_W, 32, bus data width.
- PD_ADDR, 0, address value selecting the PD register.
- MODE_ADDR, 1, address value selecting the MODE register.
- TIMEOUT, 15, max cycles m_valid stays high waiting for m_ready before abort.
- CNT_W, 16, settle counter width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse: power PA up with mode_sel
stop  in  1  pulse: power PA down
mode_sel  in  2  PA mode to program on start
settle_cycles  in  CNT_W  delay after PD=0 write before MODE write
busy  out  1  sequence in progress
done  out  1  1-cycle pulse at end of a sequence
err  out  1  sticky bus-timeout flag, cleared by the next accepted start/stop
pa_on  out  1  1 when the PA is powered and the mode is programmed
m_valid  out  1  bus request
m_address  out  1  register select
m_wdata  out  DATA_W  write data
m_wstrb  out  1  write strobe (always 1 with m_valid)
m_ready  in  1  peripheral acknowledge

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- While rst is high, all outputs are 0 and the FSM is in OFF. Reset mid-transaction drops m_valid immediately, with no completion and no done pulse.
- FSM states: OFF, UP_PD, SETTLE, UP_MODE, ON, DN_MODE, DN_PD.
- Each write state uses two sub-phases:
  - REQ: m_valid=1 and m_wstrb=1, with address and data held stable until m_ready=1 is sampled.
  - GAP: exactly 1 cycle with m_valid=0, required because the peripheral's ready is registered and stays high one cycle after valid drops.
  - The FSM advances after GAP.
- Write data and addresses:
  - UP_PD: PD_ADDR, wdata=0.
  - UP_MODE: MODE_ADDR, wdata={0,mode_sel latched at start}.
  - DN_MODE: MODE_ADDR, wdata=0.
  - DN_PD: PD_ADDR, wdata=1.
- m_valid rises the cycle after the state is entered (registered outputs). Minimum transaction is 3 cycles: REQ, ready seen, GAP.
- SETTLE: counter loads settle_cycles and decrements to 0. settle_cycles=0 gives a 1-cycle pass-through. The value is sampled at SETTLE entry.
- Transitions:
  - OFF+start → UP_PD → SETTLE → UP_MODE → ON.
  - ON+stop → DN_MODE → DN_PD → OFF.
  - ON+start → UP_MODE only (mode change, new mode_sel latched).
  - OFF+stop → no bus traffic, done pulses 1 cycle later.
- start and stop in the same cycle: stop wins.
- Commands during busy are not executed immediately:
  - A stop is latched as pending and runs immediately after the current sequence ends (done is pulsed for each sequence).
  - A start is ignored.
- busy=1 from the cycle after an accepted command until the cycle done pulses. done and the pa_on update occur in the same cycle.
- Timeout:
  - A counter runs while in REQ. If it reaches TIMEOUT without m_ready, m_valid drops, err is set, pa_on is cleared, done pulses, and the FSM goes to OFF.
  - Any pending stop is discarded.
- m_address and m_wdata keep their last value when idle. Only m_valid qualifies them.

Test Plan:
- Reset → all outputs 0. Apply start with mode_sel=2 and settle_cycles=5 → bus sees PD_ADDR/0, then ≥5 idle cycles, then MODE_ADDR/2. pa_on=1 and done pulses once.
- Power-up then stop → MODE_ADDR/0 then PD_ADDR/1, each separated by exactly 1 cycle of m_valid=0. pa_on=0, total busy cycles match the model.
- Peripheral holds m_ready low for 15 cycles during UP_PD → m_valid drops after 15 cycles, err=1, pa_on=0. The next start clears err.
- start and stop in the same cycle from OFF → no bus transaction, done pulses. stop during UP_PD → full up sequence, then immediately the down sequence, with 2 done pulses.
- ON with mode 1, then start with mode_sel=3 → a single MODE_ADDR/3 write, no PD write.
- Assert rst during SETTLE with settle_cycles=100 → m_valid=0, busy=0, pa_on=0 immediately. The FSM resumes from OFF after reset release.
